// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the hex-dump formatter. Holds the ASCII
//           constants, the nibble-to-hex helper and the state encodings used
//           by the formatter FSM and the character pacer.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // Line formatter states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_BYTE = 3'd2,
    ST_WAIT = 3'd3,
    ST_EOL  = 3'd4
  } fmt_state_t;

  // Character pacer phases: ARM waits for the tick that raises the strobe,
  // HIGH waits for the tick that lowers it, LOW waits one more tick so the
  // receiver sees a full low baud period before the next char.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ARM  = 2'd1,
    PH_HIGH = 2'd2,
    PH_LOW  = 2'd3
  } pacer_phase_t;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'd0, nib};
    return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_char_pacer.sv
`default_nettype none
// ============================================================================
// Module  : uart_char_pacer
// Purpose : Presents one ASCII char at a time with a strobe that is high for
//           exactly one baud period, so a baud-sampled edge detector sees a
//           single edge per char.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           baud_x1         - one-clk tick per baud period
//           char_in, req    - char to send, 1-clk load request (only honoured
//                             when idle)
//           char_out        - held char, stable through strobe high and low
//           char_strobe     - high for one baud period per char
//           done            - 1-clk pulse when the char has fully completed
// Revision: 1.0 - initial release
// ============================================================================
module uart_char_pacer
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_x1,
  input  logic [7:0] char_in,
  input  logic       req,
  output logic [7:0] char_out,
  output logic       char_strobe,
  output logic       done
);

  pacer_phase_t phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PH_IDLE;
      char_out    <= 8'h00;
      char_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        PH_IDLE: if (req) begin
          char_out <= char_in;
          phase    <= PH_ARM;
        end
        PH_ARM: if (baud_x1) begin
          char_strobe <= 1'b1;
          phase       <= PH_HIGH;
        end
        PH_HIGH: if (baud_x1) begin
          char_strobe <= 1'b0;
          phase       <= PH_LOW;
        end
        PH_LOW: if (baud_x1) begin
          done  <= 1'b1;
          phase <= PH_IDLE;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_hexdump_fmt.sv
`default_nettype none
// ============================================================================
// Module  : uart_hexdump_fmt
// Purpose : Turns (addr, byte) pairs into hex-dump text lines
//           "AAAA: DD DD ...\r\n", one ASCII char at a time, paced on baud_x1.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           baud_x1         - one-clk tick per baud period
//           addr, data      - offered byte and its address
//           in_valid        - byte offered
//           in_ready        - byte taken on clk where in_valid && in_ready
//           flush           - level, closes the open line with CR LF
//           char_out        - current ASCII char
//           char_strobe     - high one baud period per char
//           busy            - line open or char in flight
// Revision: 1.0 - initial release
// ============================================================================
module uart_hexdump_fmt
  import uart_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        baud_x1,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  char_out,
  output logic        char_strobe,
  output logic        busy
);

  localparam logic [4:0] BPL = 5'(BYTES_PER_LINE);

  fmt_state_t  state;
  logic [15:0] line_addr;
  logic [15:0] hold_addr;
  logic [7:0]  hold_data;
  logic [4:0]  cnt;
  logic [2:0]  idx;        // char index within the current state's token
  logic        pending;    // held byte must start a new line after EOL
  logic        in_flight;  // pacer owns the current char
  logic        req;
  logic        rdy;

  logic [7:0]  next_char;
  logic        pacer_done;
  logic        char_last;
  logic        accept;
  logic [15:0] expect_addr;
  logic [4:0]  cnt_inc;

  // flush overrides the registered ready so a same-clk flush always wins
  assign in_ready    = rdy && !flush;
  assign accept      = in_valid && in_ready;
  assign expect_addr = line_addr + {11'd0, cnt};
  assign cnt_inc     = cnt + 5'd1;

  always_comb begin
    next_char = 8'h00;
    char_last = 1'b0;
    case (state)
      ST_ADDR: begin
        char_last = (idx == 3'd4);
        case (idx)
          3'd0:    next_char = hex_to_ascii(line_addr[15:12]);
          3'd1:    next_char = hex_to_ascii(line_addr[11:8]);
          3'd2:    next_char = hex_to_ascii(line_addr[7:4]);
          3'd3:    next_char = hex_to_ascii(line_addr[3:0]);
          default: next_char = ASCII_COLON;
        endcase
      end
      ST_BYTE: begin
        char_last = (idx == 3'd2);
        case (idx)
          3'd0:    next_char = ASCII_SPACE;
          3'd1:    next_char = hex_to_ascii(hold_data[7:4]);
          default: next_char = hex_to_ascii(hold_data[3:0]);
        endcase
      end
      ST_EOL: begin
        char_last = (idx == 3'd1);
        next_char = (idx == 3'd0) ? ASCII_CR : ASCII_LF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      line_addr <= 16'h0000;
      hold_addr <= 16'h0000;
      hold_data <= 8'h00;
      cnt       <= 5'd0;
      idx       <= 3'd0;
      pending   <= 1'b0;
      in_flight <= 1'b0;
      req       <= 1'b0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            line_addr <= addr;
            hold_data <= data;
            cnt       <= 5'd0;
            idx       <= 3'd0;
            rdy       <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_ADDR;
          end else begin
            rdy <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (flush) begin
            rdy   <= 1'b0;
            idx   <= 3'd0;
            state <= ST_EOL;
          end else if (accept) begin
            hold_data <= data;
            rdy       <= 1'b0;
            idx       <= 3'd0;
            if (addr == expect_addr) begin
              state <= ST_BYTE;
            end else begin
              hold_addr <= addr;
              pending   <= 1'b1;
              state     <= ST_EOL;
            end
          end
        end

        // ADDR, BYTE, EOL: hand each char to the pacer and wait for done
        default: begin
          if (!in_flight) begin
            req       <= 1'b1;
            in_flight <= 1'b1;
          end else if (pacer_done) begin
            in_flight <= 1'b0;
            idx       <= idx + 3'd1;
            if (char_last) begin
              idx <= 3'd0;
              case (state)
                ST_ADDR: state <= ST_BYTE;
                ST_BYTE: begin
                  cnt <= cnt_inc;
                  if (cnt_inc == BPL) begin
                    state <= ST_EOL;
                  end else begin
                    state <= ST_WAIT;
                    rdy   <= 1'b1;
                  end
                end
                default: begin
                  if (pending) begin
                    line_addr <= hold_addr;
                    cnt       <= 5'd0;
                    pending   <= 1'b0;
                    state     <= ST_ADDR;
                  end else begin
                    busy  <= 1'b0;
                    rdy   <= 1'b1;
                    state <= ST_IDLE;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_char_pacer u_pacer (
    .clk         (clk),
    .reset       (reset),
    .baud_x1     (baud_x1),
    .char_in     (next_char),
    .req         (req),
    .char_out    (char_out),
    .char_strobe (char_strobe),
    .done        (pacer_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_hexdump_fmt.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_hexdump_fmt
// Purpose : Directed self-checking bench for uart_hexdump_fmt. Captures each
//           char on the strobe's rising edge and compares the captured text
//           with hand-written expected lines; also watches strobe timing.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_hexdump_fmt;

  localparam int BAUD_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        baud_x1 = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data = 8'h00;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready;
  logic [7:0]  char_out;
  logic        char_strobe;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] cap[$];
  logic [7:0] expq[$];

  uart_hexdump_fmt #(.BYTES_PER_LINE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_x1     (baud_x1),
    .addr        (addr),
    .data        (data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .char_out    (char_out),
    .char_strobe (char_strobe),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int bcnt = 0;
  always @(negedge clk) begin
    bcnt    = (bcnt + 1) % BAUD_DIV;
    baud_x1 = (bcnt == 0);
  end

  // Strobe monitor
  bit         prev_stb = 1'b0;
  bit         seen_fall = 1'b0;
  int         hi_len = 0;
  int         lo_len = 0;
  int         bad_hi = 0;
  int         bad_lo = 0;
  int         bad_stable = 0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      prev_stb  = 1'b0;
      seen_fall = 1'b0;
      hi_len    = 0;
      lo_len    = 0;
    end else begin
      if (char_strobe) begin
        if (!prev_stb) begin
          cap.push_back(char_out);
          held   = char_out;
          hi_len = 1;
          if (seen_fall && lo_len < BAUD_DIV) bad_lo++;
        end else begin
          hi_len++;
          if (char_out != held) bad_stable++;
        end
      end else begin
        if (prev_stb) begin
          if (hi_len != BAUD_DIV) bad_hi++;
          lo_len    = 1;
          seen_fall = 1'b1;
        end else begin
          lo_len++;
        end
      end
      prev_stb = char_strobe;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
  endtask

  task automatic push_crlf();
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  task automatic clear_q();
    cap.delete();
    expq.delete();
  endtask

  // Offer a byte and hold it until the handshake completes
  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) check({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr     = a;
    data     = d;
    in_valid = 1'b1;
    wait_accept("send");
  endtask

  task automatic compare(input string tag);
    for (int t = 0; t < 4000 && cap.size() < expq.size(); t++) @(negedge clk);
    repeat (60) @(negedge clk);
    check({tag, "_len"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < cap.size()) ? int'(cap[i]) : -1,
            int'(expq[i]));
  endtask

  task automatic wait_line_open(input string tag);
    bit ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (in_ready && busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_wait_timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_char_out", char_out, 8'h00);
    check("rst_strobe", char_strobe, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", in_ready, 1);

    // flush while idle produces nothing and blocks in_ready
    flush = 1'b1;
    #1 check("idle_flush_rdy", in_ready, 0);
    repeat (40) @(negedge clk);
    flush = 1'b0;
    check("idle_flush_chars", cap.size(), 0);
    check("idle_flush_busy", busy, 0);

    // 1: single byte then flush
    clear_q();
    push_str("1234: AB"); push_crlf();
    send(16'h1234, 8'hAB);
    flush = 1'b1;
    compare("t1");
    flush = 1'b0;
    check("t1_busy", busy, 0);

    // 2: full line closes itself
    clear_q();
    push_str("0100: 00 01 02 03 04 05 06 07"); push_crlf();
    for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 8'(i));
    compare("t2");
    check("t2_busy", busy, 0);

    // 3: non-contiguous address starts a new line
    clear_q();
    push_str("0010: 11"); push_crlf(); push_str("0040: 22");
    send(16'h0010, 8'h11);
    send(16'h0040, 8'h22);
    compare("t3");
    check("t3_busy_open", busy, 1);
    check("t3_rdy_open", in_ready, 1);
    clear_q();
    push_crlf();
    flush = 1'b1;
    compare("t3_close");
    flush = 1'b0;

    // 4: address wrap FFFF -> 0000 is contiguous
    clear_q();
    push_str("FFFF: 01 02"); push_crlf();
    send(16'hFFFF, 8'h01);
    send(16'h0000, 8'h02);
    flush = 1'b1;
    compare("t4");
    flush = 1'b0;

    // 5: flush and in_valid together in WAIT
    clear_q();
    push_str("0200: 55"); push_crlf(); push_str("0201: 66");
    send(16'h0200, 8'h55);
    wait_line_open("t5");
    flush    = 1'b1;
    addr     = 16'h0201;
    data     = 8'h66;
    in_valid = 1'b1;
    #1 check("t5_flush_wins", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    wait_accept("t5");
    compare("t5");
    clear_q();
    push_crlf();
    flush = 1'b1;
    compare("t5_close");
    flush = 1'b0;

    // 6: reset during the third char abandons the line
    clear_q();
    send(16'h3456, 8'h78);
    for (int t = 0; t < 3000 && cap.size() < 3; t++) @(negedge clk);
    check("t6_third_char", (cap.size() >= 3) ? int'(cap[2]) : -1, 8'h35);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_strobe", char_strobe, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rdy", in_ready, 0);
    reset = 1'b0;
    clear_q();
    @(negedge clk);
    #1 check("t6_rdy_after", in_ready, 1);
    push_str("0A0B: CD"); push_crlf();
    send(16'h0A0B, 8'hCD);
    flush = 1'b1;
    compare("t6");
    flush = 1'b0;

    check("strobe_high_width", bad_hi, 0);
    check("strobe_low_width", bad_lo, 0);
    check("char_stable", bad_stable, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
